// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing constants for the instruction fetch queue.
//   FETCH_WIDTH / FETCH_DEPTH : default address/instruction width and ring depth
//   PTR_W                     : ring pointer width (DEPTH is a power of two)
//   CNT_W                     : width of the count / drop counters (0..DEPTH)
//   fetch_entry_t             : one ring slot {pc, instr, filled}
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int PTR_W       = $clog2(FETCH_DEPTH);
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
    logic                   filled;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: turns accepted PCs into in-order instruction memory
// requests, buffers returned words with their PC in a DEPTH-entry ring and
// hands them to decode. A flush discards everything buffered or in flight.
//
// Ports:
//   clk, rst                       clock; asynchronous active-high reset
//   pc_valid_i, pc_i, pc_ready_o   PC offered / address / accepted this cycle
//   flush_i                        redirect: discard all buffered and in-flight
//   imem_req_valid_o/_ready_i      memory request handshake
//   imem_addr_o                    word-aligned request address
//   imem_rsp_valid_i/_data_i       in-order memory responses (>=1 cycle latency)
//   if_valid_o, if_instr_o, if_pc_o, id_ready_i   head entry to decode
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge. The PC handshake and the memory request are the
// same event (pc_ready_o = imem_req_valid_o & imem_req_ready_i). Decode takes
// the head entry when if_valid_o & id_ready_i.
//
// The ring sizing comes from fetch_pkg; WIDTH/DEPTH must match its defaults.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FETCH_WIDTH,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_valid_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_ready_o,
  input  logic             flush_i,
  output logic             imem_req_valid_o,
  input  logic             imem_req_ready_i,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_rsp_valid_i,
  input  logic [WIDTH-1:0] imem_rsp_data_i,
  output logic             if_valid_o,
  output logic [WIDTH-1:0] if_instr_o,
  output logic [WIDTH-1:0] if_pc_o,
  input  logic             id_ready_i
);

  fetch_entry_t     ring [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] fill_ptr;
  // count: allocated entries; owed: allocated entries still waiting for data;
  // drop_cnt: responses still owed by requests issued before a flush.
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] owed;
  logic [CNT_W-1:0] drop_cnt;

  logic [CNT_W:0]   outstanding;
  logic             space;
  logic             issue;
  logic             consume;
  logic             rsp_fill;
  logic             rsp_drop;

  // Registered count only: a slot freed by decode this cycle is not reused
  // until the next cycle. Dropped responses still occupy memory bandwidth,
  // so they count against the outstanding limit too.
  assign outstanding = {1'b0, count} + {1'b0, drop_cnt};
  assign space       = outstanding < (CNT_W+1)'(DEPTH);

  assign imem_req_valid_o = pc_valid_i & space & ~flush_i;
  assign imem_addr_o      = {pc_i[WIDTH-1:2], 2'b00};
  assign issue            = imem_req_valid_o & imem_req_ready_i;
  assign pc_ready_o       = issue;

  assign if_valid_o = ring[head].filled & (count != '0) & ~flush_i;
  assign if_instr_o = ring[head].instr;
  assign if_pc_o    = ring[head].pc;
  assign consume    = if_valid_o & id_ready_i;

  assign rsp_drop = imem_rsp_valid_i & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid_i & (drop_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      owed     <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
    end else if (flush_i) begin
      // Every unfilled allocation becomes a response to throw away; a
      // response arriving right now is one of those owed ones and is
      // discarded on the spot.
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      owed     <= '0;
      drop_cnt <= drop_cnt + owed - CNT_W'(imem_rsp_valid_i);
      for (int i = 0; i < DEPTH; i++) begin
        ring[i].filled <= 1'b0;
      end
    end else begin
      // issue, fill and consume always touch distinct slots: issue needs a
      // free slot, fill targets an unfilled one, consume a filled one.
      if (issue) begin
        ring[tail].pc     <= pc_i;
        ring[tail].filled <= 1'b0;
        tail              <= tail + 1'b1;
      end
      if (rsp_fill) begin
        ring[fill_ptr].instr  <= imem_rsp_data_i;
        ring[fill_ptr].filled <= 1'b1;
        fill_ptr              <= fill_ptr + 1'b1;
      end
      if (consume) begin
        ring[head].filled <= 1'b0;
        head              <= head + 1'b1;
      end
      count <= count + CNT_W'(issue) - CNT_W'(consume);
      owed  <= owed + CNT_W'(issue) - CNT_W'(rsp_fill);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // A response must belong either to a pre-flush request or to an allocated
  // entry still waiting for its data.
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid_i |-> ((drop_cnt != '0) || (owed != '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: self-checking bench for instr_fetch_queue.
// Drives the PC side and decode side directly, models instruction memory with
// configurable latency and request back-pressure, and checks every cycle
// against an entry-queue reference model plus table and hand-written cases.
module tb_instr_fetch_queue;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         clk;
  logic         rst;
  logic         pc_valid_i;
  logic [W-1:0] pc_i;
  logic         pc_ready_o;
  logic         flush_i;
  logic         imem_req_valid_o;
  logic         imem_req_ready_i;
  logic [W-1:0] imem_addr_o;
  logic         imem_rsp_valid_i;
  logic [W-1:0] imem_rsp_data_i;
  logic         if_valid_o;
  logic [W-1:0] if_instr_o;
  logic [W-1:0] if_pc_o;
  logic         id_ready_i;

  instr_fetch_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_valid_i       (pc_valid_i),
    .pc_i             (pc_i),
    .pc_ready_o       (pc_ready_o),
    .flush_i          (flush_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .if_valid_o       (if_valid_o),
    .if_instr_o       (if_instr_o),
    .if_pc_o          (if_pc_o),
    .id_ready_i       (id_ready_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  bit rand_lat = 1'b0;
  int n_acc    = 0;
  int n_dec    = 0;

  // memory model: accepted requests waiting for their response slot
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } mreq_t;
  mreq_t mq[$];

  // reference model: allocated entries in program order
  logic [W-1:0] exp_q[$];
  bit           fill_q[$];
  int           mdl_drop = 0;

  // sampled DUT outputs of the last step
  logic         s_pc_ready, s_req_valid, s_if_valid;
  logic [W-1:0] s_addr, s_if_pc, s_if_instr;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Caller sets the PC/flush/ready inputs; step drives the memory response,
  // checks outputs at the falling edge, advances the model and the memory.
  task automatic step();
    bit   space, e_req, e_ifv, done;
    int   unf;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mq[0].data;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    @(negedge clk);
    space = (exp_q.size() + mdl_drop) < DEPTH;
    e_req = pc_valid_i && space && !flush_i;
    e_ifv = 1'b0;
    if (exp_q.size() > 0) e_ifv = fill_q[0] && !flush_i;

    s_pc_ready  = pc_ready_o;
    s_req_valid = imem_req_valid_o;
    s_addr      = imem_addr_o;
    s_if_valid  = if_valid_o;
    s_if_pc     = if_pc_o;
    s_if_instr  = if_instr_o;

    chk("req_valid", {31'b0, s_req_valid}, {31'b0, e_req});
    chk("pc_ready", {31'b0, s_pc_ready}, {31'b0, e_req && imem_req_ready_i});
    if (e_req) chk("imem_addr", s_addr, pc_i & ~32'h3);
    chk("if_valid", {31'b0, s_if_valid}, {31'b0, e_ifv});
    if (e_ifv) begin
      chk("if_pc", s_if_pc, exp_q[0]);
      chk("if_instr", s_if_instr, mem_word(exp_q[0] & ~32'h3));
    end

    if (flush_i) begin
      unf = 0;
      foreach (fill_q[i]) if (!fill_q[i]) unf++;
      mdl_drop = mdl_drop + unf - (imem_rsp_valid_i ? 1 : 0);
      exp_q.delete();
      fill_q.delete();
    end else begin
      if (imem_rsp_valid_i) begin
        if (mdl_drop > 0) mdl_drop--;
        else begin
          done = 1'b0;
          foreach (fill_q[i]) if (!done && !fill_q[i]) begin
            fill_q[i] = 1'b1;
            done = 1'b1;
          end
        end
      end
      if (e_ifv && id_ready_i) begin
        void'(exp_q.pop_front());
        void'(fill_q.pop_front());
        n_dec++;
      end
      if (e_req && imem_req_ready_i) begin
        exp_q.push_back(pc_i);
        fill_q.push_back(1'b0);
        n_acc++;
      end
    end

    if (imem_rsp_valid_i) void'(mq.pop_front());
    if (imem_req_valid_o && imem_req_ready_i)
      mq.push_back('{data: mem_word(imem_addr_o),
                     due: cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_models();
    mq.delete();
    exp_q.delete();
    fill_q.delete();
    mdl_drop = 0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
  endtask

  task automatic drain();
    bit empty;
    pc_valid_i = 1'b0;
    flush_i = 1'b0;
    id_ready_i = 1'b1;
    imem_req_ready_i = 1'b1;
    empty = 1'b0;
    for (int i = 0; i < 60 && !empty; i++) begin
      step();
      empty = (exp_q.size() == 0) && (mq.size() == 0) && (mdl_drop == 0);
    end
    chk("drain_done", {31'b0, empty}, 32'd1);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    bit           pc_valid;
    logic [W-1:0] pc;
    bit           exp_pc_ready;
    bit           exp_if_valid;
    logic [W-1:0] exp_if_pc;
  } vec_t;
  vec_t vecs[10];

  initial begin
    bit           seen;
    logic [W-1:0] first_pc;

    // streaming at latency 1, memory and decode always ready
    vecs[0] = '{1'b1, 32'h00, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h04, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h08, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h08, 1'b1, 1'b1, 32'h4};
    vecs[4] = '{1'b1, 32'h0C, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h10, 1'b0, 1'b1, 32'h8};
    vecs[6] = '{1'b1, 32'h10, 1'b1, 1'b1, 32'hC};
    vecs[7] = '{1'b0, 32'h14, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 32'h14, 1'b0, 1'b1, 32'h10};
    vecs[9] = '{1'b0, 32'h14, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    pc_valid_i = 1'b0;
    pc_i = '0;
    flush_i = 1'b0;
    imem_req_ready_i = 1'b0;
    id_ready_i = 1'b0;
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_if_pc", if_pc_o, 32'd0);
    chk("rst_if_instr", if_instr_o, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("rst_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    rst = 1'b0;

    // table-driven streaming
    lat = 1;
    imem_req_ready_i = 1'b1;
    id_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc_valid_i = vecs[i].pc_valid;
      pc_i = vecs[i].pc;
      step();
      chk($sformatf("tbl%0d_pc_ready", i), {31'b0, s_pc_ready}, {31'b0, vecs[i].exp_pc_ready});
      chk($sformatf("tbl%0d_if_valid", i), {31'b0, s_if_valid}, {31'b0, vecs[i].exp_if_valid});
      if (vecs[i].exp_if_valid) begin
        chk($sformatf("tbl%0d_if_pc", i), s_if_pc, vecs[i].exp_if_pc);
        chk($sformatf("tbl%0d_if_instr", i), s_if_instr, mem_word(vecs[i].exp_if_pc));
      end
    end
    drain();

    // decode stall: two accepts then the queue blocks issue
    id_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h200;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_pc_ready) pc_i = pc_i + 4;
    end
    chk("stall_accepts", n_acc, 32'd2);
    chk("stall_pc_ready", {31'b0, s_pc_ready}, 32'd0);
    chk("stall_req_valid", {31'b0, s_req_valid}, 32'd0);
    n_dec = 0;
    drain();
    chk("stall_drained", n_dec, 32'd2);

    // flush with two outstanding at latency 3
    lat = 3;
    pc_valid_i = 1'b1;
    pc_i = 32'h10;
    step();
    chk("flush_iss0", {31'b0, s_pc_ready}, 32'd1);
    pc_i = 32'h14;
    step();
    chk("flush_iss1", {31'b0, s_pc_ready}, 32'd1);
    pc_valid_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h100;
    step();
    chk("flush_drop_block", {31'b0, s_pc_ready}, 32'd0);
    step();
    chk("flush_resume", {31'b0, s_pc_ready}, 32'd1);
    pc_valid_i = 1'b0;
    seen = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (s_if_valid) begin
        seen = 1'b1;
        first_pc = s_if_pc;
      end
    end
    chk("flush_seen", {31'b0, seen}, 32'd1);
    chk("flush_first_pc", first_pc, 32'h100);
    drain();

    // flush in the same cycle as the only response
    lat = 2;
    pc_valid_i = 1'b1;
    pc_i = 32'h20;
    step();
    pc_valid_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    chk("coinc_if_valid", {31'b0, s_if_valid}, 32'd0);
    flush_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h24;
    step();
    chk("coinc_iss0", {31'b0, s_pc_ready}, 32'd1);
    pc_i = 32'h28;
    step();
    chk("coinc_iss1", {31'b0, s_pc_ready}, 32'd1);
    drain();

    // memory back-pressure
    lat = 1;
    imem_req_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_pc_ready", {31'b0, s_pc_ready}, 32'd0);
      chk("bp_req_valid", {31'b0, s_req_valid}, 32'd1);
    end
    imem_req_ready_i = 1'b1;
    step();
    chk("bp_issue", {31'b0, s_pc_ready}, 32'd1);
    chk("bp_addr", s_addr, 32'h40);
    drain();

    // asynchronous reset with two filled entries
    id_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_pc_ready) pc_i = pc_i + 4;
    end
    chk("pre_rst_valid", {31'b0, s_if_valid}, 32'd1);
    #2;
    rst = 1'b1;
    pc_valid_i = 1'b0;
    clear_models();
    #1;
    chk("arst_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("arst_if_pc", if_pc_o, 32'd0);
    chk("arst_if_instr", if_instr_o, 32'd0);
    chk("arst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_ready_i = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 32'h0;
    step();
    chk("arst_refetch", {31'b0, s_pc_ready}, 32'd1);
    pc_valid_i = 1'b0;
    seen = 1'b0;
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (s_if_valid) begin
        seen = 1'b1;
        first_pc = s_if_pc;
      end
    end
    chk("arst_seen", {31'b0, seen}, 32'd1);
    chk("arst_first_pc", first_pc, 32'h0);
    drain();

    // randomized traffic against the reference model
    rand_lat = 1'b1;
    pc_i = $urandom;
    for (int i = 0; i < 400; i++) begin
      pc_valid_i = ($urandom_range(0, 3) != 0);
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      id_ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
      step();
      if (s_pc_ready || flush_i) pc_i = $urandom;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
